// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory nibble loader.
// Word layout: opcode[15:12], rd[11:8], rs[7:4], rt/imm[3:0].
package imem_loader_pkg;

  localparam int ADDR_W           = 8;
  localparam int DATA_W           = 16;
  localparam int NIB_W            = 4;
  localparam int NIBBLES_PER_WORD = 4;
  localparam int DEPTH            = 256;
  localparam int CNT_W            = $clog2(NIBBLES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Nibble-stream handshake plus program-memory write bus of the loader.
// master = nibble source / memory side, slave = the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  logic                             nib_valid;
  logic [imem_loader_pkg::NIB_W-1:0] nib_data;
  logic                             nib_ready;
  logic                             wr_en;
  logic [ADDR_W-1:0]                wr_addr;
  logic [DATA_W-1:0]                wr_data;

  modport master (
    output nib_valid, nib_data,
    input  nib_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  nib_valid, nib_data,
    output nib_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Shifts nibbles MSB-first into an instruction word and counts nibbles
// received; the shift register itself is the loader's write-data register.
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift,
  input  logic [NIB_W-1:0]  nib,
  output logic [WORD_W-1:0] word,
  output logic [CNT_W-1:0]  count,
  output logic              last
);

  logic [WORD_W-1:0] word_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              last_s;

  assign last_s = (cnt_r == CNT_W'(NIBBLES_PER_WORD - 1));

  // Shift register and nibble counter; counter wraps to 0 after the last nibble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r <= '0;
      cnt_r  <= '0;
    end else if (clear) begin
      word_r <= '0;
      cnt_r  <= '0;
    end else if (shift) begin
      word_r <= {word_r[WORD_W-NIB_W-1:0], nib};
      cnt_r  <= last_s ? '0 : cnt_r + CNT_W'(1);
    end else begin
      word_r <= word_r;
      cnt_r  <= cnt_r;
    end
  end

  assign word  = word_r;
  assign count = cnt_r;
  assign last  = last_s;

endmodule

// File: rtl/imem_loader.sv
// Loads a CPU program memory from a 4-bit nibble stream: assembles 16-bit
// words, writes them to consecutive addresses and holds the CPU meanwhile.
module imem_loader #(
  parameter int ADDR_W = imem_loader_pkg::ADDR_W,
  parameter int DATA_W = imem_loader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err,
  output logic              done
);

  import imem_loader_pkg::*;

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] COLLECT = ST_COLLECT;
  localparam logic [1:0] WRITE   = ST_WRITE;
  localparam logic [1:0] DONE    = ST_DONE;

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  logic [1:0]        state_r, state_next_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   wc_r;
  logic              full_r, err_r;
  logic              nib_ready_r, wr_en_r, cpu_hold_r, done_r;
  logic              xfer_s, clear_s;
  logic [DATA_W-1:0] word_s;
  logic [CNT_W-1:0]  nib_cnt_s;
  logic              last_nib_s;

  word_assembler #(.WORD_W(DATA_W)) u_asm (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_s),
    .shift (xfer_s),
    .nib   (bus.nib_data),
    .word  (word_s),
    .count (nib_cnt_s),
    .last  (last_nib_s)
  );

  // Next-state logic; finish beats a simultaneous nibble, which is dropped
  always_comb begin
    state_next_s = state_r;
    clear_s      = 1'b0;
    xfer_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = COLLECT;
          clear_s      = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      COLLECT: begin
        if (finish) begin
          state_next_s = DONE;
          clear_s      = 1'b1;
        end else if (bus.nib_valid) begin
          xfer_s       = 1'b1;
          state_next_s = last_nib_s ? WRITE : COLLECT;
        end else begin
          state_next_s = COLLECT;
        end
      end
      WRITE: begin
        if ((addr_r == ADDR_LAST) || finish) begin
          state_next_s = DONE;
        end else begin
          state_next_s = COLLECT;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, session counters/flags, and output strobes registered from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      wc_r        <= '0;
      full_r      <= 1'b0;
      err_r       <= 1'b0;
      nib_ready_r <= 1'b0;
      wr_en_r     <= 1'b0;
      cpu_hold_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      nib_ready_r <= (state_next_s == COLLECT);
      wr_en_r     <= (state_next_s == WRITE);
      cpu_hold_r  <= (state_next_s == COLLECT) || (state_next_s == WRITE);
      done_r      <= (state_next_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            addr_r <= '0;
            wc_r   <= '0;
            full_r <= 1'b0;
            err_r  <= 1'b0;
          end
        end
        COLLECT: begin
          if (finish) begin
            err_r <= (nib_cnt_s != '0);
          end
        end
        WRITE: begin
          wc_r <= wc_r + (ADDR_W+1)'(1);
          // The top address saturates rather than wrapping onto word 0
          if (addr_r == ADDR_LAST) begin
            full_r <= 1'b1;
          end else begin
            addr_r <= addr_r + ADDR_W'(1);
          end
        end
        default: begin
          addr_r <= addr_r;
        end
      endcase
    end
  end

  assign bus.nib_ready = nib_ready_r;
  assign bus.wr_en     = wr_en_r;
  assign bus.wr_addr   = addr_r;
  assign bus.wr_data   = word_s;
  assign cpu_hold      = cpu_hold_r;
  assign word_count    = wc_r;
  assign full          = full_r;
  assign err           = err_r;
  assign done          = done_r;

endmodule
